// File: rtl/irq_controller_pkg.sv
// Shared types and limits for the prioritised interrupt controller.
package irq_ctrl_pkg;

   localparam int NUM_IRQ_MIN = 2;
   localparam int NUM_IRQ_MAX = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IRQ_REQ = 3'd1,
      IRQ_SVC = 3'd2,
      NMI_REQ = 3'd3,
      NMI_SVC = 3'd4
   } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_priority_encoder
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] i_eligible,
   output logic [VEC_W-1:0]   o_index,
   output logic               o_valid
);

   always_comb begin
      o_index = '0;
      o_valid = |i_eligible;
      // Scan high to low so the last hit, the lowest index, is kept.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (i_eligible[i]) begin
            o_index = VEC_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches NUM_IRQ maskable channels plus an NMI and
// runs the request/ack/done handshake with the processor control unit.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int                 NUM_IRQ    = 8,
   parameter int                 VEC_W      = $clog2(NUM_IRQ),
   parameter logic [NUM_IRQ-1:0] EDGE_MODE  = '1,
   parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_nmi,
   input  logic               i_int_disable,
   input  logic               i_mask_we,
   input  logic [NUM_IRQ-1:0] i_mask_wdata,
   input  logic               i_int_ack,
   input  logic               i_nmi_ack,
   input  logic               i_int_done,
   output logic               o_int_req,
   output logic [VEC_W-1:0]   o_int_vector,
   output logic               o_nmi_req,
   output logic               o_in_service,
   output logic [NUM_IRQ-1:0] o_pending,
   output logic [NUM_IRQ-1:0] o_mask
);

   irq_state_e         r_state;
   irq_state_e         w_state_nxt;
   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] r_mask;
   logic               r_nmi_q;
   logic               r_nmi_pend;
   logic               r_int_dis;
   logic [VEC_W-1:0]   r_vec;
   logic               r_int_req;
   logic               r_nmi_req;
   logic               r_in_service;

   logic [NUM_IRQ-1:0] w_irq_rise;
   logic [NUM_IRQ-1:0] w_ack_clr;
   logic [NUM_IRQ-1:0] w_pend_nxt;
   logic [NUM_IRQ-1:0] w_eligible;
   logic [VEC_W-1:0]   w_enc_idx;
   logic               w_enc_vld;
   logic               w_ack_take;
   logic               w_nmi_ack_take;
   logic               w_nmi_rise;

   assign w_irq_rise     = i_irq & ~r_irq_q;
   assign w_nmi_rise     = i_nmi & ~r_nmi_q;
   assign w_ack_take     = (r_state == IRQ_REQ) && i_int_ack;
   assign w_nmi_ack_take = (r_state == NMI_REQ) && i_nmi_ack;
   assign w_ack_clr      = w_ack_take ? (NUM_IRQ'(1) << r_vec) : '0;

   // Edge bits: a fresh rise beats the ack clear. Level bits track the line.
   assign w_pend_nxt = (EDGE_MODE & ((r_pending & ~w_ack_clr) | w_irq_rise))
                     | (~EDGE_MODE & i_irq);

   // int_disable is sampled like the request lines so both share latency.
   assign w_eligible = r_pending & ~r_mask & {NUM_IRQ{~r_int_dis}};

   irq_priority_encoder #(
      .NUM_IRQ (NUM_IRQ),
      .VEC_W   (VEC_W)
   ) u_prio (
      .i_eligible (w_eligible),
      .o_index    (w_enc_idx),
      .o_valid    (w_enc_vld)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_nmi_pend)     w_state_nxt = NMI_REQ;
            else if (w_enc_vld) w_state_nxt = IRQ_REQ;
         end
         IRQ_REQ: begin
            if (i_int_ack)       w_state_nxt = IRQ_SVC;
            else if (r_nmi_pend) w_state_nxt = NMI_REQ;
            else if (r_int_dis)  w_state_nxt = IDLE;
         end
         IRQ_SVC: if (i_int_done) w_state_nxt = IDLE;
         NMI_REQ: if (i_nmi_ack)  w_state_nxt = NMI_SVC;
         NMI_SVC: if (i_int_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_irq_q      <= '0;
         r_pending    <= '0;
         r_mask       <= MASK_RESET;
         r_nmi_q      <= 1'b0;
         r_nmi_pend   <= 1'b0;
         r_int_dis    <= 1'b0;
         r_vec        <= '0;
         r_int_req    <= 1'b0;
         r_nmi_req    <= 1'b0;
         r_in_service <= 1'b0;
      end else begin
         r_irq_q    <= i_irq;
         r_pending  <= w_pend_nxt;
         r_nmi_q    <= i_nmi;
         r_nmi_pend <= w_nmi_rise | (r_nmi_pend & ~w_nmi_ack_take);
         r_int_dis  <= i_int_disable;
         if (i_mask_we) begin
            r_mask <= i_mask_wdata;
         end
         // The vector is frozen from request until the next arbitration.
         if (r_state == IDLE && w_state_nxt == IRQ_REQ) begin
            r_vec <= w_enc_idx;
         end
         r_int_req    <= (w_state_nxt == IRQ_REQ);
         r_nmi_req    <= (w_state_nxt == NMI_REQ);
         r_in_service <= (w_state_nxt == IRQ_SVC) || (w_state_nxt == NMI_SVC);
      end
   end

   assign o_int_req    = r_int_req;
   assign o_int_vector = r_vec;
   assign o_nmi_req    = r_nmi_req;
   assign o_in_service = r_in_service;
   assign o_pending    = r_pending;
   assign o_mask       = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Directed vector bench for irq_controller; channel 3 is level, others edge.
module tb_irq_controller;

   localparam int NUM_IRQ = 8;
   localparam int VEC_W   = 3;

   localparam logic [6:0] C_0    = 7'h00;
   localparam logic [6:0] C_RST  = 7'h40;
   localparam logic [6:0] C_NMI  = 7'h20;
   localparam logic [6:0] C_DIS  = 7'h10;
   localparam logic [6:0] C_WE   = 7'h08;
   localparam logic [6:0] C_ACK  = 7'h04;
   localparam logic [6:0] C_NACK = 7'h02;
   localparam logic [6:0] C_DONE = 7'h01;

   typedef struct {
      logic [6:0]         ctl;
      logic [NUM_IRQ-1:0] irq;
      logic [NUM_IRQ-1:0] wd;
      logic               req;
      logic [VEC_W-1:0]   vec;
      logic               nreq;
      logic               svc;
      logic [NUM_IRQ-1:0] pend;
      logic [NUM_IRQ-1:0] mask;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst, nmi, int_disable, mask_we, int_ack, nmi_ack, int_done;
   logic [NUM_IRQ-1:0] irq, mask_wdata;
   logic               int_req, nmi_req, in_service;
   logic [VEC_W-1:0]   int_vector;
   logic [NUM_IRQ-1:0] pending, mask;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   irq_controller #(
      .NUM_IRQ    (NUM_IRQ),
      .VEC_W      (VEC_W),
      .EDGE_MODE  (8'hF7),
      .MASK_RESET (8'hFF)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_irq         (irq),
      .i_nmi         (nmi),
      .i_int_disable (int_disable),
      .i_mask_we     (mask_we),
      .i_mask_wdata  (mask_wdata),
      .i_int_ack     (int_ack),
      .i_nmi_ack     (nmi_ack),
      .i_int_done    (int_done),
      .o_int_req     (int_req),
      .o_int_vector  (int_vector),
      .o_nmi_req     (nmi_req),
      .o_in_service  (in_service),
      .o_pending     (pending),
      .o_mask        (mask)
   );

   task automatic add(input logic [6:0] c, input logic [7:0] i, input logic [7:0] w,
                      input logic rq, input logic [2:0] v, input logic nr, input logic sv,
                      input logic [7:0] p, input logic [7:0] m);
      vec_t t;
      t.ctl = c; t.irq = i; t.wd = w; t.req = rq; t.vec = v;
      t.nreq = nr; t.svc = sv; t.pend = p; t.mask = m;
      vq.push_back(t);
   endtask

   task automatic drive(input logic [6:0] c, input logic [7:0] i, input logic [7:0] w);
      {rst, nmi, int_disable, mask_we, int_ack, nmi_ack, int_done} = c;
      irq        = i;
      mask_wdata = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      //   ctl              irq    wd     rq vec nr sv pend   mask
      add(C_RST,           8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
      add(C_RST,           8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
      // single edge request on channel 2
      add(C_WE,            8'h00, 8'hF0, 0, 0, 0, 0, 8'h00, 8'hF0);
      add(C_0,             8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 8'hF0);
      add(C_0,             8'h00, 8'h00, 1, 2, 0, 0, 8'h04, 8'hF0);
      add(C_ACK,           8'h00, 8'h00, 0, 2, 0, 1, 8'h00, 8'hF0);
      add(C_0,             8'h00, 8'h00, 0, 2, 0, 1, 8'h00, 8'hF0);
      add(C_DONE,          8'h00, 8'h00, 0, 2, 0, 0, 8'h00, 8'hF0);
      add(C_0,             8'h00, 8'h00, 0, 2, 0, 0, 8'h00, 8'hF0);
      // channels 5 and 1 together
      add(C_WE,            8'h00, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
      add(C_0,             8'h22, 8'h00, 0, 2, 0, 0, 8'h22, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 1, 0, 0, 8'h22, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 1, 0, 1, 8'h20, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 1, 0, 0, 8'h20, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 5, 0, 0, 8'h20, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 5, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 5, 0, 0, 8'h00, 8'h00);
      // level channel 3: held re-requests, dropped does not
      add(C_0,             8'h08, 8'h00, 0, 5, 0, 0, 8'h08, 8'h00);
      add(C_0,             8'h08, 8'h00, 1, 3, 0, 0, 8'h08, 8'h00);
      add(C_ACK,           8'h08, 8'h00, 0, 3, 0, 1, 8'h08, 8'h00);
      add(C_DONE,          8'h08, 8'h00, 0, 3, 0, 0, 8'h08, 8'h00);
      add(C_0,             8'h08, 8'h00, 1, 3, 0, 0, 8'h08, 8'h00);
      add(C_ACK,           8'h08, 8'h00, 0, 3, 0, 1, 8'h08, 8'h00);
      add(C_0,             8'h00, 8'h00, 0, 3, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 3, 0, 0, 8'h00, 8'h00);
      add(C_0,             8'h00, 8'h00, 0, 3, 0, 0, 8'h00, 8'h00);
      // NMI preempts an unacked request on channel 4
      add(C_0,             8'h10, 8'h00, 0, 3, 0, 0, 8'h10, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 4, 0, 0, 8'h10, 8'h00);
      add(C_NMI,           8'h00, 8'h00, 1, 4, 0, 0, 8'h10, 8'h00);
      add(C_NMI,           8'h00, 8'h00, 0, 4, 1, 0, 8'h10, 8'h00);
      add(C_NACK,          8'h00, 8'h00, 0, 4, 0, 1, 8'h10, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 4, 0, 0, 8'h10, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 4, 0, 0, 8'h10, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 4, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 4, 0, 0, 8'h00, 8'h00);
      // global disable blocks channel 0 but not NMI
      add(C_DIS,           8'h01, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_DIS|C_NMI,     8'h00, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 0, 4, 1, 0, 8'h01, 8'h00);
      add(C_DIS|C_NACK,    8'h00, 8'h00, 0, 4, 0, 1, 8'h01, 8'h00);
      add(C_DIS|C_DONE,    8'h00, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_0,             8'h00, 8'h00, 0, 4, 0, 0, 8'h01, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 0, 0, 0, 8'h01, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      // reset in service drops everything, including a fresh edge
      add(C_0,             8'h40, 8'h00, 0, 0, 0, 0, 8'h40, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 6, 0, 0, 8'h40, 8'h00);
      add(C_ACK,           8'h80, 8'h00, 0, 6, 0, 1, 8'h80, 8'h00);
      add(C_RST,           8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
      add(C_0,             8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
      // mask after latch, ack with new edge, ack+NMI rise, stray acks
      add(C_WE,            8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(C_0,             8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 2, 0, 0, 8'h04, 8'h00);
      add(C_WE,            8'h00, 8'h04, 1, 2, 0, 0, 8'h04, 8'h04);
      add(C_ACK|C_NMI,     8'h04, 8'h00, 0, 2, 0, 1, 8'h04, 8'h04);
      add(C_NMI|C_NACK,    8'h04, 8'h00, 0, 2, 0, 1, 8'h04, 8'h04);
      add(C_DONE,          8'h00, 8'h00, 0, 2, 0, 0, 8'h04, 8'h04);
      add(C_0,             8'h00, 8'h00, 0, 2, 1, 0, 8'h04, 8'h04);
      add(C_ACK|C_NACK,    8'h00, 8'h00, 0, 2, 0, 1, 8'h04, 8'h04);
      add(C_WE,            8'h00, 8'h00, 0, 2, 0, 1, 8'h04, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 2, 0, 0, 8'h04, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 2, 0, 0, 8'h04, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 2, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
      // ack beats disable; disable alone withdraws the request
      add(C_0,             8'h01, 8'h00, 0, 2, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 1, 0, 0, 0, 8'h01, 8'h00);
      add(C_DIS|C_ACK,     8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(C_0,             8'h01, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 0, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 1, 0, 0, 0, 8'h01, 8'h00);
      add(C_DIS,           8'h00, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00);
      add(C_0,             8'h00, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00);
      add(C_0,             8'h00, 8'h00, 1, 0, 0, 0, 8'h01, 8'h00);
      add(C_ACK,           8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00);
      add(C_DONE,          8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);

      drive(C_RST, 8'h00, 8'h00);
      #2;
      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].ctl, vq[k].irq, vq[k].wd);
         tick();
         n_vec++;
         if ({int_req, int_vector, nmi_req, in_service, pending, mask} !==
             {vq[k].req, vq[k].vec, vq[k].nreq, vq[k].svc, vq[k].pend, vq[k].mask}) begin
            n_bad++;
            $display("FAIL vec%0d: got req=%b vec=%0d nreq=%b svc=%b pend=%h mask=%h expected req=%b vec=%0d nreq=%b svc=%b pend=%h mask=%h",
                     k, int_req, int_vector, nmi_req, in_service, pending, mask,
                     vq[k].req, vq[k].vec, vq[k].nreq, vq[k].svc, vq[k].pend, vq[k].mask);
         end
      end

      // NMI rising again during NMI service is served after done
      drive(C_NMI, 8'h00, 8'h00);  tick(); chk("nmi_pend_only", {nmi_req, in_service}, 2'b00);
      drive(C_0, 8'h00, 8'h00);    tick(); chk("nmi_req_1",     {nmi_req, in_service}, 2'b10);
      drive(C_NACK, 8'h00, 8'h00); tick(); chk("nmi_svc_1",     {nmi_req, in_service}, 2'b01);
      drive(C_NMI, 8'h00, 8'h00);  tick(); chk("nmi_rerise",    {nmi_req, in_service}, 2'b01);
      drive(C_DONE, 8'h00, 8'h00); tick(); chk("nmi_done_1",    {nmi_req, in_service}, 2'b00);
      drive(C_0, 8'h00, 8'h00);    tick(); chk("nmi_req_2",     {nmi_req, in_service}, 2'b10);
      drive(C_NACK, 8'h00, 8'h00); tick(); chk("nmi_svc_2",     {nmi_req, in_service}, 2'b01);
      drive(C_DONE, 8'h00, 8'h00); tick(); chk("nmi_done_2",    {nmi_req, in_service}, 2'b00);
      drive(C_0, 8'h00, 8'h00);    tick(); chk("nmi_quiet",     {int_req, nmi_req, in_service}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
